regfile_scoreboard: RTL



---
 rtl/regfile_scoreboard_if.sv | 31 +++
 rtl/regfile_scoreboard.sv | 80 ++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Bundles the read, writeback and issue signals of the register file.
// The master drives IDs and strobes; the slave (the register file) returns data, busy and wordlines.
interface regfile_scoreboard_if #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16
);
  logic [ADDR_W-1:0]   src1_id;
  logic [ADDR_W-1:0]   src2_id;
  logic [DATA_W-1:0]   src1_data;
  logic [DATA_W-1:0]   src2_data;
  logic                src1_busy;
  logic                src2_busy;
  logic [NUM_REGS-1:0] src1_wordline;
  logic [NUM_REGS-1:0] src2_wordline;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_id;
  logic [DATA_W-1:0]   wr_data;
  logic                issue_en;
  logic [ADDR_W-1:0]   issue_id;

  modport master (
    output src1_id, src2_id, wr_en, wr_id, wr_data, issue_en, issue_id,
    input  src1_data, src2_data, src1_busy, src2_busy, src1_wordline, src2_wordline
  );

  modport slave (
    input  src1_id, src2_id, wr_en, wr_id, wr_data, issue_en, issue_id,
    output src1_data, src2_data, src1_busy, src2_busy, src1_wordline, src2_wordline
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with one-hot read decode, optional write-to-read bypass and a
// per-register busy scoreboard for the decode-stage hazard unit.
module regfile_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 0
) (
  input logic clk,
  input logic rst,
  regfile_scoreboard_if.slave rf
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  function automatic logic id_legal(input logic [ADDR_W-1:0] id);
    return ({1'b0, id} < NUM_REGS_W) && !((ZERO_R0 != 0) && (id == '0));
  endfunction

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_legal;
  logic                issue_legal;
  logic [NUM_REGS-1:0] wl1;
  logic [NUM_REGS-1:0] wl2;
  logic [DATA_W-1:0]   stored1;
  logic [DATA_W-1:0]   stored2;
  logic                hit1;
  logic                hit2;
  logic                issue_hit1;
  logic                issue_hit2;

  // Reset gates the strobes so bypass and writes are suppressed while rst is high.
  assign wr_legal    = !rst && rf.wr_en    && id_legal(rf.wr_id);
  assign issue_legal = !rst && rf.issue_en && id_legal(rf.issue_id);

  // Issue takes priority over a same-edge writeback: the new producer is still outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      busy <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_legal && (rf.wr_id == ADDR_W'(k))) regs[k] <= rf.wr_data;
        if (issue_legal && (rf.issue_id == ADDR_W'(k)))  busy[k] <= 1'b1;
        else if (wr_legal && (rf.wr_id == ADDR_W'(k)))   busy[k] <= 1'b0;
      end
    end
  end

  always_comb begin
    wl1     = '0;
    wl2     = '0;
    stored1 = '0;
    stored2 = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      wl1[k] = (rf.src1_id == ADDR_W'(k));
      wl2[k] = (rf.src2_id == ADDR_W'(k));
      if (!((ZERO_R0 != 0) && (k == 0))) begin
        if (wl1[k]) stored1 = stored1 | regs[k];
        if (wl2[k]) stored2 = stored2 | regs[k];
      end
    end
  end

  assign hit1       = (BYPASS != 0) && wr_legal && (rf.wr_id == rf.src1_id);
  assign hit2       = (BYPASS != 0) && wr_legal && (rf.wr_id == rf.src2_id);
  assign issue_hit1 = rf.issue_en && (rf.issue_id == rf.src1_id);
  assign issue_hit2 = rf.issue_en && (rf.issue_id == rf.src2_id);

  assign rf.src1_wordline = wl1;
  assign rf.src2_wordline = wl2;
  assign rf.src1_data     = hit1 ? rf.wr_data : stored1;
  assign rf.src2_data     = hit2 ? rf.wr_data : stored2;
  // A forwarded writeback resolves the hazard unless a new producer issues in the same cycle.
  assign rf.src1_busy     = (|(wl1 & busy)) && !(hit1 && !issue_hit1);
  assign rf.src2_busy     = (|(wl2 & busy)) && !(hit2 && !issue_hit2);

endmodule
